// File: rtl/gat_pkg.sv
// Shared types and default widths for the GAT BRAM loader.
// Target encoding, FSM states and default port widths.
package gat_pkg;

  typedef enum logic [1:0] {
    TGT_H_DATA    = 2'd0,
    TGT_NODE_INFO = 2'd1,
    TGT_WEIGHT    = 2'd2,
    TGT_RSVD      = 2'd3
  } target_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int H_DATA_WIDTH_D     = 19;
  localparam int NODE_INFO_WIDTH_D  = 20;
  localparam int DATA_WIDTH_D       = 8;
  localparam int H_DATA_ADDR_W_D    = 18;
  localparam int NODE_INFO_ADDR_W_D = 14;
  localparam int WEIGHT_ADDR_W_D    = 15;

endpackage

// File: rtl/gat_bram_loader_if.sv
// Input word stream for the GAT BRAM loader.
// master drives words, slave (the loader) drives ready.
interface gat_bram_loader_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready
  );
endinterface

// File: rtl/gat_bram_wr_port.sv
// Registered single-port BRAM write driver.
// Outputs are zero on every cycle that does not carry a write.
module gat_bram_wr_port #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  input  logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] din,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W+1:0] addra
);

  // one-cycle write pulse with byte address, zeroed when idle
  always_ff @(posedge clk) begin
    if (rst || !we) begin
      din   <= '0;
      ena   <= 1'b0;
      wea   <= 1'b0;
      addra <= '0;
    end else begin
      din   <= d;
      ena   <= 1'b1;
      wea   <= 1'b1;
      addra <= {a, 2'b00};
    end
  end

endmodule

// File: rtl/gat_bram_loader.sv
// Streams words into one of three BRAMs (h_data, node_info, weight).
// Define GAT_LOADER_LEN_CHECK_EN to enable length/s_last checking.
module gat_bram_loader
  import gat_pkg::*;
#(
  parameter int H_DATA_WIDTH     = H_DATA_WIDTH_D,
  parameter int NODE_INFO_WIDTH  = NODE_INFO_WIDTH_D,
  parameter int DATA_WIDTH       = DATA_WIDTH_D,
  parameter int H_DATA_ADDR_W    = H_DATA_ADDR_W_D,
  parameter int NODE_INFO_ADDR_W = NODE_INFO_ADDR_W_D,
  parameter int WEIGHT_ADDR_W    = WEIGHT_ADDR_W_D
) (
  input  logic                        clk,
  input  logic                        rst,
  gat_bram_loader_if.slave            s,
  input  logic                        start,
  input  logic [1:0]                  target,
  input  logic [31:0]                 length,
  output logic                        busy,
  output logic [H_DATA_WIDTH-1:0]     h_data_bram_din,
  output logic                        h_data_bram_ena,
  output logic                        h_data_bram_wea,
  output logic [H_DATA_ADDR_W+1:0]    h_data_bram_addra,
  output logic [NODE_INFO_WIDTH-1:0]  h_node_info_bram_din,
  output logic                        h_node_info_bram_ena,
  output logic                        h_node_info_bram_wea,
  output logic [NODE_INFO_ADDR_W+1:0] h_node_info_bram_addra,
  output logic [DATA_WIDTH-1:0]       wgt_bram_din,
  output logic                        wgt_bram_ena,
  output logic                        wgt_bram_wea,
  output logic [WEIGHT_ADDR_W+1:0]    wgt_bram_addra,
  output logic                        h_data_bram_load_done,
  output logic                        h_node_info_bram_load_done,
  output logic                        wgt_bram_load_done,
  output logic                        err
);

  state_e      state, nxt;
  target_e     tgt_q;
  logic [31:0] len_q;
  logic [31:0] cnt_q;
  logic [2:0]  done_q;

  logic start_ok;
  logic accept;
  logic last_word;
  logic early_last;

  assign start_ok  = start && (target != TGT_RSVD) && (length != 32'd0);
  assign accept    = (state == LOAD) && s.s_valid;
  assign last_word = (cnt_q == len_q - 32'd1);

`ifdef GAT_LOADER_LEN_CHECK_EN
  assign early_last = accept && s.s_last && !last_word;
`else
  assign early_last = 1'b0;
`endif

  assign s.s_ready = (state == LOAD);
  assign busy      = (state == LOAD);

  assign h_data_bram_load_done      = done_q[0];
  assign h_node_info_bram_load_done = done_q[1];
  assign wgt_bram_load_done         = done_q[2];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start_ok) nxt = LOAD;
      LOAD: begin
        if (accept && last_word) nxt = DONE;
        else if (early_last)     nxt = IDLE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // load context, word counter and sticky done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q  <= TGT_H_DATA;
      len_q  <= '0;
      cnt_q  <= '0;
      done_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (start_ok) begin
          tgt_q <= target_e'(target);
          len_q <= length;
          cnt_q <= '0;
          unique case (1'b1)
            target == TGT_H_DATA:    done_q[0] <= 1'b0;
            target == TGT_NODE_INFO: done_q[1] <= 1'b0;
            target == TGT_WEIGHT:    done_q[2] <= 1'b0;
            default: ;
          endcase
        end
        LOAD: if (accept) cnt_q <= cnt_q + 32'd1;
        DONE: begin
          unique case (1'b1)
            tgt_q == TGT_H_DATA:    done_q[0] <= 1'b1;
            tgt_q == TGT_NODE_INFO: done_q[1] <= 1'b1;
            tgt_q == TGT_WEIGHT:    done_q[2] <= 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef GAT_LOADER_LEN_CHECK_EN
  logic err_q;
  // sticky length error: early s_last, or missing s_last on final word
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == IDLE && start_ok) begin
      err_q <= 1'b0;
    end else if (early_last || (accept && last_word && !s.s_last)) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  logic unused_last;
  assign unused_last = s.s_last;
  assign err = 1'b0;
`endif

  logic unused_data;
  assign unused_data = ^s.s_data;

  gat_bram_wr_port #(
    .DATA_W (H_DATA_WIDTH),
    .ADDR_W (H_DATA_ADDR_W)
  ) u_h_data (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && tgt_q == TGT_H_DATA),
    .d     (s.s_data[H_DATA_WIDTH-1:0]),
    .a     (cnt_q[H_DATA_ADDR_W-1:0]),
    .din   (h_data_bram_din),
    .ena   (h_data_bram_ena),
    .wea   (h_data_bram_wea),
    .addra (h_data_bram_addra)
  );

  gat_bram_wr_port #(
    .DATA_W (NODE_INFO_WIDTH),
    .ADDR_W (NODE_INFO_ADDR_W)
  ) u_node_info (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && tgt_q == TGT_NODE_INFO),
    .d     (s.s_data[NODE_INFO_WIDTH-1:0]),
    .a     (cnt_q[NODE_INFO_ADDR_W-1:0]),
    .din   (h_node_info_bram_din),
    .ena   (h_node_info_bram_ena),
    .wea   (h_node_info_bram_wea),
    .addra (h_node_info_bram_addra)
  );

  gat_bram_wr_port #(
    .DATA_W (DATA_WIDTH),
    .ADDR_W (WEIGHT_ADDR_W)
  ) u_wgt (
    .clk   (clk),
    .rst   (rst),
    .we    (accept && tgt_q == TGT_WEIGHT),
    .d     (s.s_data[DATA_WIDTH-1:0]),
    .a     (cnt_q[WEIGHT_ADDR_W-1:0]),
    .din   (wgt_bram_din),
    .ena   (wgt_bram_ena),
    .wea   (wgt_bram_wea),
    .addra (wgt_bram_addra)
  );

endmodule

// File: tb/tb_gat_bram_loader.sv
// Directed bench for gat_bram_loader with a write scoreboard.
// Honours GAT_LOADER_LEN_CHECK_EN the same way as the design.
module tb_gat_bram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  target;
  logic [31:0] length;
  logic        busy;
  logic [18:0] h_din;
  logic        h_ena, h_wea;
  logic [19:0] h_addr;
  logic [19:0] n_din;
  logic        n_ena, n_wea;
  logic [15:0] n_addr;
  logic [7:0]  w_din;
  logic        w_ena, w_wea;
  logic [16:0] w_addr;
  logic        h_done, n_done, w_done;
  logic        err;

  gat_bram_loader_if sif ();

  gat_bram_loader dut (
    .clk                        (clk),
    .rst                        (rst),
    .s                          (sif),
    .start                      (start),
    .target                     (target),
    .length                     (length),
    .busy                       (busy),
    .h_data_bram_din            (h_din),
    .h_data_bram_ena            (h_ena),
    .h_data_bram_wea            (h_wea),
    .h_data_bram_addra          (h_addr),
    .h_node_info_bram_din       (n_din),
    .h_node_info_bram_ena       (n_ena),
    .h_node_info_bram_wea       (n_wea),
    .h_node_info_bram_addra     (n_addr),
    .wgt_bram_din               (w_din),
    .wgt_bram_ena               (w_ena),
    .wgt_bram_wea               (w_wea),
    .wgt_bram_addra             (w_addr),
    .h_data_bram_load_done      (h_done),
    .h_node_info_bram_load_done (n_done),
    .wgt_bram_load_done         (w_done),
    .err                        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         mon_en = 0;
  logic [2:0] exp_done;

  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon(int p, logic ena, logic wea,
                     logic [31:0] din, logic [31:0] addr);
    wr_t e;
    if (ena) begin
      tests++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL wr_unexp: got port %0d addr %0h expected no write",
               p, addr);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wr_port", 64'(p), 64'(e.port));
        chk("wr_cyc", 64'(cyc), 64'(e.cyc));
        chk("wr_addr", 64'(addr), 64'(e.addr));
        chk("wr_data", 64'(din), 64'(e.data));
        chk("wr_wea", 64'(wea), 64'd1);
      end
    end else begin
      chk("idle_port", {wea, din, addr}, 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, h_ena, h_wea, 32'(h_din), 32'(h_addr));
      mon(1, n_ena, n_wea, 32'(n_din), 32'(n_addr));
      mon(2, w_ena, w_wea, 32'(w_din), 32'(w_addr));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [1:0] t, logic [31:0] l);
    start  = 1'b1;
    target = t;
    length = l;
    tick();
    start  = 1'b0;
  endtask

  task automatic send(logic [31:0] d, logic last, int p,
                      int idx, logic [31:0] exp_d);
    wr_t e;
    e.port = p;
    e.cyc  = cyc + 1;
    e.addr = 32'(idx * 4);
    e.data = exp_d;
    q.push_back(e);
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = last;
    tick();
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic chk_flags(string tag);
    chk(tag, 64'({w_done, n_done, h_done}), 64'(exp_done));
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    target      = 2'd0;
    length      = 32'd0;
    sif.s_valid = 1'b0;
    sif.s_data  = 32'd0;
    sif.s_last  = 1'b0;
    exp_done    = 3'b000;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(sif.s_ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ena", 64'({h_ena, n_ena, w_ena}), 64'd0);
    chk_flags("rst_done");
    mon_en = 1;

    // weight load, 4 words; start during LOAD/DONE ignored
    do_start(2'd2, 32'd4);
    chk("w_busy", 64'(busy), 64'd1);
    chk("w_ready", 64'(sif.s_ready), 64'd1);
    start  = 1'b1;
    target = 2'd1;
    length = 32'd1;
    send(32'h11, 1'b0, 2, 0, 32'h11);
    start = 1'b0;
    for (int i = 1; i < 4; i++)
      send(32'h11 + 32'(i), 1'b0, 2, i, 32'h11 + 32'(i));
    chk("w_done_busy", 64'(busy), 64'd0);
    chk("w_done_ready", 64'(sif.s_ready), 64'd0);
    do_start(2'd0, 32'd1);
    exp_done[2] = 1'b1;
    chk("w_ign_busy", 64'(busy), 64'd0);
    chk_flags("w_flags");
    chk("w_q_empty", 64'(q.size()), 64'd0);

    // h_data load, truncation and valid gaps
    do_start(2'd0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      send(32'hFFFF_FFFF, 1'b0, 0, i, 32'h7FFFF);
      if (i < 2) begin
        tick();
        tick();
      end
    end
    chk("h_busy_done", 64'(busy), 64'd0);
    tick();
    exp_done[0] = 1'b1;
    chk_flags("h_flags");

    // ignored starts
    do_start(2'd3, 32'd5);
    chk("rsvd_busy", 64'(busy), 64'd0);
    tick();
    do_start(2'd1, 32'd0);
    chk("len0_busy", 64'(busy), 64'd0);
    tick();
    chk_flags("ign_flags");
    chk("ign_q_empty", 64'(q.size()), 64'd0);

    // reset mid-load, pending write discarded
    do_start(2'd2, 32'd5);
    exp_done[2] = 1'b0;
    send(32'h21, 1'b0, 2, 0, 32'h21);
    send(32'h22, 1'b0, 2, 1, 32'h22);
    sif.s_valid = 1'b1;
    sif.s_data  = 32'h23;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sif.s_valid = 1'b0;
    exp_done = 3'b000;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_ready", 64'(sif.s_ready), 64'd0);
    chk("mrst_err", 64'(err), 64'd0);
    chk("mrst_wgt", 64'({w_ena, w_wea, w_din, w_addr}), 64'd0);
    chk_flags("mrst_flags");
    do_start(2'd1, 32'd1);
    send(32'hFFFA_BCDE, 1'b1, 1, 0, 32'hABCDE);
    tick();
    exp_done[1] = 1'b1;
    chk_flags("n_flags");

    // early s_last
    do_start(2'd0, 32'd4);
    send(32'h31, 1'b0, 0, 0, 32'h31);
    send(32'h32, 1'b1, 0, 1, 32'h32);
`ifdef GAT_LOADER_LEN_CHECK_EN
    chk("el_busy", 64'(busy), 64'd0);
    chk("el_err", 64'(err), 64'd1);
    tick();
    chk_flags("el_flags");
    chk("el_err_hold", 64'(err), 64'd1);
    do_start(2'd2, 32'd1);
    chk("el_err_clr", 64'(err), 64'd0);
    send(32'h5A, 1'b1, 2, 0, 32'h5A);
    tick();
    exp_done[2] = 1'b1;
    chk("ok_err", 64'(err), 64'd0);
    chk_flags("ok_flags");
    do_start(2'd2, 32'd2);
    send(32'h61, 1'b0, 2, 0, 32'h61);
    send(32'h62, 1'b0, 2, 1, 32'h62);
    chk("nolast_err", 64'(err), 64'd1);
    tick();
    chk_flags("nolast_flags");
`else
    send(32'h33, 1'b0, 0, 2, 32'h33);
    send(32'h34, 1'b0, 0, 3, 32'h34);
    tick();
    exp_done[0] = 1'b1;
    chk("el_err", 64'(err), 64'd0);
    chk_flags("el_flags");
`endif
    tick();
    chk("end_q_empty", 64'(q.size()), 64'd0);
    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
